// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        LD_HDR  = 3'd0,
        LD_LOAD = 3'd1,
        LD_CHK  = 3'd2,
        LD_DONE = 3'd3,
        LD_ERR  = 3'd4
    } ld_state_e;

    // Length of the little-endian word-count header, in bytes.
    localparam int unsigned HDR_BYTES = 4;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Byte packer: gathers four little-endian bytes into one 32-bit word.
module imem_loader_byte_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  idx_q;
    logic [31:0] data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= 2'd0;
            data_q <= 32'd0;
        end else if (clr) begin
            idx_q  <= 2'd0;
            data_q <= 32'd0;
        end else if (byte_valid) begin
            data_q[8*idx_q +: 8] <= byte_data;
            idx_q                <= idx_q + 2'd1;
        end
    end

    // The word on the 4th byte includes that byte combinationally, so the
    // caller can register it on the same edge the byte is accepted.
    always_comb begin
        word                = data_q;
        word[8*idx_q +: 8]  = byte_data;
    end

    assign word_valid = byte_valid && !clr && (idx_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Loads a framed byte stream into instruction memory and releases the core
// only once the image checksum verifies.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned MAX_WORDS = 2**ADDR_W - BASE_ADDR
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err
);

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    ld_state_e         state_q, state_d;
    logic [31:0]       cnt_q, cnt_d;
    logic [1:0]        hdr_idx_q, hdr_idx_d;
    // One spare bit: the index must be able to reach MAX_WORDS itself.
    logic [ADDR_W:0]   word_idx_q, word_idx_d;
    logic [7:0]        sum_q, sum_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;

    logic              accept;
    logic              pk_clr;
    logic              pk_valid;
    logic              pk_word_valid;
    logic [31:0]       pk_word;

    assign in_ready = (state_q == LD_HDR) || (state_q == LD_LOAD) || (state_q == LD_CHK);
    assign accept   = in_valid && in_ready;

    imem_loader_byte_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (pk_clr),
        .byte_valid (pk_valid),
        .byte_data  (in_data),
        .word_valid (pk_word_valid),
        .word       (pk_word)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hdr_idx_d  = hdr_idx_q;
        word_idx_d = word_idx_q;
        sum_d      = sum_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        pk_clr     = 1'b0;
        pk_valid   = 1'b0;

        case (state_q)
            LD_HDR: begin
                if (accept) begin
                    cnt_d[8*hdr_idx_q +: 8] = in_data;
                    hdr_idx_d               = hdr_idx_q + 2'd1;
                    if (hdr_idx_q == 2'(HDR_BYTES - 1)) begin
                        if (cnt_d > MAX_WORDS) begin
                            state_d = LD_ERR;
                        end else if (cnt_d == 32'd0) begin
                            state_d = LD_CHK;
                        end else begin
                            state_d = LD_LOAD;
                            pk_clr  = 1'b1;
                        end
                    end
                end
            end
            LD_LOAD: begin
                pk_valid = accept;
                if (accept) begin
                    sum_d = sum_q + in_data;
                end
                if (pk_word_valid) begin
                    we_d       = 1'b1;
                    addr_d     = BASE + word_idx_q[ADDR_W-1:0];
                    wdata_d    = pk_word;
                    word_idx_d = word_idx_q + 1'b1;
                    if (32'(word_idx_d) == cnt_q) begin
                        state_d = LD_CHK;
                    end
                end
            end
            LD_CHK: begin
                if (accept) begin
                    state_d = (in_data == sum_q) ? LD_DONE : LD_ERR;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= LD_HDR;
            cnt_q      <= 32'd0;
            hdr_idx_q  <= 2'd0;
            word_idx_q <= '0;
            sum_q      <= 8'd0;
            we_q       <= 1'b0;
            addr_q     <= BASE;
            wdata_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hdr_idx_q  <= hdr_idx_d;
            word_idx_q <= word_idx_d;
            sum_q      <= sum_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign cpu_hold   = (state_q != LD_DONE);
    assign load_done  = (state_q == LD_DONE);
    assign load_err   = (state_q == LD_ERR);

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: framing, checksum, size bound, stalls and mid-frame reset.
module tb_imem_loader;

    localparam int unsigned ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'd0;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_hold;
    logic              load_done;
    logic              load_err;

    int checks   = 0;
    int failures = 0;

    logic [ADDR_W-1:0] wa[$];
    logic [31:0]       wd[$];
    logic [7:0]        frame[$];
    int                stall_pat[8] = '{0, 2, 1, 0, 3, 0, 1, 2};

    imem_loader #(
        .ADDR_W (ADDR_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    always #5 clk = ~clk;

    // Write log, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n && imem_we) begin
            wa.push_back(imem_addr);
            wd.push_back(imem_wdata);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_range(input int first, input int last, input bit stall);
        for (int i = first; i <= last; i++) begin
            send(frame[i]);
            if (stall) repeat (stall_pat[i % 8]) @(negedge clk);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        wa.delete();
        wd.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // Reset values
        do_reset();
        chk("rst_hold", 32'(cpu_hold), 32'd1);
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_we", 32'(imem_we), 32'd0);
        chk("rst_done", 32'(load_done), 32'd0);
        chk("rst_err", 32'(load_err), 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'd0);
        chk("rst_wdata", imem_wdata, 32'd0);

        // Good two-word frame, with write-latency checks
        frame = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                  8'hB3, 8'h00, 8'h50, 8'h00, 8'h16};
        send_range(0, 7, 1'b0);
        chk("w0_we", 32'(imem_we), 32'd1);
        chk("w0_addr", 32'(imem_addr), 32'd0);
        chk("w0_data", imem_wdata, 32'h0000_0013);
        send(frame[8]);
        chk("w0_we_drop", 32'(imem_we), 32'd0);
        send_range(9, 11, 1'b0);
        chk("w1_we", 32'(imem_we), 32'd1);
        chk("w1_addr", 32'(imem_addr), 32'd1);
        chk("w1_data", imem_wdata, 32'h0050_00B3);
        chk("chk_ready", 32'(in_ready), 32'd1);
        chk("chk_hold", 32'(cpu_hold), 32'd1);
        send(frame[12]);
        chk("ok_done", 32'(load_done), 32'd1);
        chk("ok_err", 32'(load_err), 32'd0);
        chk("ok_hold", 32'(cpu_hold), 32'd0);
        chk("ok_ready", 32'(in_ready), 32'd0);
        send(8'hAA);
        idle(2);
        chk("ok_nwr", wa.size(), 32'd2);
        chk("ok_a0", 32'(wa[0]), 32'd0);
        chk("ok_d0", wd[0], 32'h0000_0013);
        chk("ok_a1", 32'(wa[1]), 32'd1);
        chk("ok_d1", wd[1], 32'h0050_00B3);
        chk("ok_sticky", 32'(load_done), 32'd1);

        // Same frame, wrong checksum
        do_reset();
        frame[12] = 8'h17;
        send_range(0, 12, 1'b0);
        idle(2);
        chk("bad_err", 32'(load_err), 32'd1);
        chk("bad_done", 32'(load_done), 32'd0);
        chk("bad_hold", 32'(cpu_hold), 32'd1);
        chk("bad_nwr", wa.size(), 32'd2);

        // Empty image, good then bad checksum
        do_reset();
        frame = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_range(0, 3, 1'b0);
        chk("n0_ready", 32'(in_ready), 32'd1);
        send(frame[4]);
        idle(2);
        chk("n0_done", 32'(load_done), 32'd1);
        chk("n0_hold", 32'(cpu_hold), 32'd0);
        chk("n0_nwr", wa.size(), 32'd0);
        do_reset();
        frame[4] = 8'h01;
        send_range(0, 4, 1'b0);
        chk("n0b_err", 32'(load_err), 32'd1);
        chk("n0b_done", 32'(load_done), 32'd0);

        // Oversize: N = 1025
        do_reset();
        frame = '{8'h01, 8'h04, 8'h00, 8'h00};
        send_range(0, 3, 1'b0);
        chk("big_err", 32'(load_err), 32'd1);
        chk("big_ready", 32'(in_ready), 32'd0);
        chk("big_hold", 32'(cpu_hold), 32'd1);
        idle(2);
        chk("big_nwr", wa.size(), 32'd0);

        // Three words with stalls, reset after the 6th payload byte
        do_reset();
        frame = '{8'h03, 8'h00, 8'h00, 8'h00,
                  8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                  8'h08, 8'h09, 8'h0A, 8'h0B, 8'h42};
        send_range(0, 9, 1'b1);
        chk("mid_nwr", wa.size(), 32'd1);
        chk("mid_d0", wd[0], 32'h0302_0100);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_we", 32'(imem_we), 32'd0);
        chk("mid_rst_addr", 32'(imem_addr), 32'd0);
        chk("mid_rst_wdata", imem_wdata, 32'd0);
        chk("mid_rst_hold", 32'(cpu_hold), 32'd1);
        chk("mid_rst_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_flags", {30'd0, load_done, load_err}, 32'd0);
        wa.delete();
        wd.delete();
        idle(2);
        rst_n = 1'b1;
        send_range(0, 16, 1'b1);
        idle(2);
        chk("re_nwr", wa.size(), 32'd3);
        chk("re_a0", 32'(wa[0]), 32'd0);
        chk("re_d0", wd[0], 32'h0302_0100);
        chk("re_a1", 32'(wa[1]), 32'd1);
        chk("re_d1", wd[1], 32'h0706_0504);
        chk("re_a2", 32'(wa[2]), 32'd2);
        chk("re_d2", wd[2], 32'h0B0A_0908);
        chk("re_done", 32'(load_done), 32'd1);
        chk("re_hold", 32'(cpu_hold), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time instruction-memory writer, the producer side of the instruction stream that the core's decode/control path consumes. It accepts a framed little-endian byte stream from a UART receiver over a valid/ready handshake and packs it into 32-bit instruction words. It writes those words into instruction memory and holds the core in reset until the image is loaded and its checksum verifies. It sits between the serial RX block and the imem write port, and drives the core's hold input.

## Interface
- `ADDR_W`, 10, imem word-address width.
- `BASE_ADDR`, 0, word address of the first loaded instruction.
- `MAX_WORDS`, 2**ADDR_W − BASE_ADDR, largest accepted image, in words.
- `clk`  in  1  single system clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  byte available from RX.
- `in_data`  in  8  byte value.
- `in_ready`  out  1  loader accepts the byte this cycle; a byte transfers when `in_valid && in_ready`.
- `imem_we`  out  1  single-cycle imem write strobe.
- `imem_addr`  out  ADDR_W  word address of the write.
- `imem_wdata`  out  32  instruction word.
- `cpu_hold`  out  1  keeps the core in reset while high.
- `load_done`  out  1  image loaded and checksum OK; sticky.
- `load_err`  out  1  oversize image or checksum mismatch; sticky.

## Operation
- Frame: 4-byte word count N (LSB first), then N×4 payload bytes (each word LSB first), then 1 checksum byte.
- Checksum = 8-bit sum, mod 256, of payload bytes only.
- FSM states: HDR → LOAD → CHK → DONE | ERR.
- HDR: accepts 4 bytes into the count register.
  - After byte 4: N > MAX_WORDS → ERR.
  - N == 0 → CHK.
  - Otherwise → LOAD.
- LOAD:
  - Accepts bytes into the packer and adds each byte to the running checksum.
  - On every 4th byte, issues the write (see Timing) and increments the word counter.
  - After word N → CHK.
- CHK:
  - Accepts 1 byte.
  - Byte equals the running sum → DONE; otherwise → ERR.
- DONE: `load_done`=1, `cpu_hold`=0, `in_ready`=0. Stays until reset.
- ERR: `load_err`=1, `cpu_hold`=1, `in_ready`=0. Stays until reset.
- `in_ready` = 1 in HDR, LOAD and CHK. No backpressure is needed because the write completes in a single cycle.
- Address = BASE_ADDR + word index (0..N−1). No wrap occurs because the N bound guarantees it.
- Bytes presented in DONE or ERR are not accepted.

## Timing
- Reset values:
  - state HDR
  - `in_ready`=1
  - `imem_we`=0
  - `imem_addr`=BASE_ADDR
  - `imem_wdata`=0
  - `cpu_hold`=1
  - `load_done`=0
  - `load_err`=0
  - count, byte index, word index and checksum all 0.
- Write latency: the 4th byte of a word is accepted at edge k. At edge k+1, `imem_we`=1 with registered `imem_addr`/`imem_wdata`. At edge k+2, `imem_we` returns to 0 unless the next word completes.
- Back-to-back bytes every cycle are supported, so the write rate is at most one write per 4 cycles.
- Exit from LOAD: the final word's write strobe and the state's move to CHK occur in the same cycle. CHK may accept a byte in that same cycle.
- DONE/ERR entry: the flag and `cpu_hold` change on the edge after the deciding byte is accepted.
- `cpu_hold` falls no earlier than the cycle after the last `imem_we`.
- `in_valid` low stalls all counters. The FSM holds indefinitely and has no timeout.
- Reset asserted mid-frame: all state clears immediately and asynchronously, and `cpu_hold` goes to 1. Any write in flight is dropped. After release, the next byte is treated as header byte 0.

## Structure
- FSM state encodings (3-bit `LD_HDR`, `LD_LOAD`, `LD_CHK`, `LD_DONE`, `LD_ERR`) and the header length constant (4) go in `define.v`.
- Sub-module `byte_packer`:
  - Holds a 2-bit byte index and a 32-bit shift register that puts byte i into bits [8i+7:8i].
  - Emits `word_valid` for one cycle on the 4th byte.
  - Has a synchronous clear input, used on HDR→LOAD.
- Top level: FSM, count/word-index/checksum registers, output registers.

## Test plan
- Reset only → `cpu_hold`=1, `in_ready`=1, `imem_we`=0, `load_done`=`load_err`=0.
- Frame `02 00 00 00 | 13 00 00 00 | B3 00 50 00 | 16` → writes 0x00000013 at address 0 and 0x005000B3 at address 1. Then `load_done`=1, `cpu_hold`=0.
- Same frame, checksum byte 0x17 → both writes occur, then `load_err`=1, `cpu_hold` stays 1, `load_done`=0.
- Header N=0 (`00 00 00 00`) then checksum `00` → no `imem_we`, `load_done`=1. Repeat with checksum `01` → `load_err`=1.
- Header N = MAX_WORDS+1 → ERR right after header byte 4 with no writes, and `in_ready`=0 afterwards.
- `in_valid` toggling randomly during a 3-word load, plus `rst_n` pulsed low after the 6th payload byte → writes stop and outputs return to reset values. A fresh complete frame then loads correctly from BASE_ADDR.
